fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core: holds the program counter, requests instructions from instruction memory over a valid/ready-style handshake, and latches the returned word into an instruction register. The latched instruction fields (`op`, `funct3`, `funct7`) feed the control unit directly. The control unit's `pcSrc`, together with the branch/jump target from the datapath, selects the next PC when the core retires the current instruction.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/valid handshake, holds it in the instruction register until the core
// retires it, then steps to pc+4 or the control-selected target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        advance,
  input  logic        pcSrc,
  input  logic [31:0] pcTarget,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_ERROR} state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        trap_q, trap_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic: accept a response in FETCH, retire/redirect in HOLD.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    trap_d    = trap_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (advance) begin
          retired_d = retired_q + 32'd1;
          // A misaligned taken target is fatal; pc keeps the faulting
          // instruction's address for debug.
          if (pcSrc && (pcTarget[1:0] != 2'b00)) begin
            trap_d  = 1'b1;
            state_d = S_ERROR;
          end else begin
            pc_d    = pcSrc ? pcTarget : pc_plus4;
            state_d = S_FETCH;
          end
        end
      end
      S_ERROR: begin
        trap_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP;
      retired_q <= 32'd0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  // Reset gates the request combinationally so an in-flight fetch is dropped
  // in the same cycle reset is raised.
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign instrValid = (state_q == S_HOLD);
  assign op         = instr_q[6:0];
  assign funct3     = instr_q[14:12];
  assign funct7     = instr_q[30];
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign trap       = trap_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps plus randomized fetch/retire traffic,
// checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        advance;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic [31:0] instr;
  logic        instrValid;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        trap;
  logic [31:0] retired;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .advance(advance), .pcSrc(pcSrc), .pcTarget(pcTarget),
    .instr(instr), .instrValid(instrValid),
    .op(op), .funct3(funct3), .funct7(funct7),
    .pc(pc), .pcPlus4(pcPlus4), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the fetch stage should be showing right now.
  logic [31:0] m_pc, m_instr, m_retired;
  logic        m_valid, m_trap, m_dead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".pc4"}, pcPlus4, m_pc + 32'd4);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".op"}, {25'd0, op}, {25'd0, m_instr[6:0]});
    chk({tag, ".f3"}, {29'd0, funct3}, {29'd0, m_instr[14:12]});
    chk({tag, ".f7"}, {31'd0, funct7}, {31'd0, m_instr[30]});
    chk({tag, ".valid"}, {31'd0, instrValid}, {31'd0, m_valid});
    chk({tag, ".trap"}, {31'd0, trap}, {31'd0, m_trap});
    chk({tag, ".retired"}, retired, m_retired);
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, !m_valid && !m_dead && !reset});
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_valid = 1'b0; advance = 1'b0;
    #1;
    chk("rst.req_now", {31'd0, imem_req}, 32'd0);
    step();
    chk("rst.req_held", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    m_pc = RPC; m_instr = 32'h0000_0013; m_retired = 0;
    m_valid = 0; m_trap = 0; m_dead = 0;
    #1;
    chk_state("rst");
  endtask

  // Memory answers after lat wait cycles; advance noise in the wait is ignored.
  task automatic do_fetch(input int lat, input logic [31:0] word);
    logic [31:0] junk;
    for (int i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      advance    = 1'($urandom_range(0, 1));
      pcSrc      = 1'($urandom_range(0, 1));
      pcTarget   = $urandom;
      #1;
      chk("wait.req", {31'd0, imem_req}, 32'd1);
      chk("wait.addr", imem_addr, m_pc);
      step();
      chk("wait.retired", retired, m_retired);
      chk("wait.valid", {31'd0, instrValid}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    advance    = 1'($urandom_range(0, 1));
    #1;
    chk("resp.req", {31'd0, imem_req}, 32'd1);
    chk("resp.addr", imem_addr, m_pc);
    step();
    advance = 1'b0;
    imem_valid = 1'b0;
    junk = $urandom;
    imem_rdata = junk;
    m_instr = word; m_valid = 1;
    chk_state("fetch");
  endtask

  // A stray response while holding must not disturb the held word.
  task automatic stray_resp();
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    step();
    imem_valid = 1'b0;
    chk_state("stray");
  endtask

  task automatic do_advance(input logic src, input logic [31:0] tgt);
    advance = 1'b1; pcSrc = src; pcTarget = tgt;
    step();
    advance = 1'b0;
    pcSrc = $urandom_range(0, 1);
    pcTarget = $urandom;
    m_retired = m_retired + 1;
    m_valid = 0;
    if (src && tgt[1:0] != 2'b00) begin
      m_trap = 1; m_dead = 1;
    end else begin
      m_pc = src ? tgt : m_pc + 32'd4;
    end
    chk_state("adv");
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1; imem_valid = 1'b0; imem_rdata = 0;
    advance = 1'b0; pcSrc = 1'b0; pcTarget = 0;
    step();

    // Reset and zero-wait first fetch.
    do_reset();
    do_fetch(0, 32'h0050_0093);
    chk("first.op", {25'd0, op}, 32'h13);
    chk("first.pc", pc, 32'h100);

    // Wait states at the reset PC, then sequential step.
    do_reset();
    do_fetch(3, 32'h4000_5033);
    stray_resp();
    do_advance(1'b0, 32'h0000_0043);
    chk("seq.addr", imem_addr, 32'h104);
    chk("seq.retired", retired, 32'd1);

    // Taken branch.
    do_fetch(1, 32'h0000_0063);
    do_advance(1'b1, 32'h0000_0040);
    chk("br.addr", imem_addr, 32'h40);

    // Randomized traffic with aligned taken targets.
    for (int it = 0; it < 40; it++) begin
      r = $urandom;
      do_fetch($urandom_range(0, 3), r);
      if ($urandom_range(0, 3) == 0) stray_resp();
      r = $urandom;
      if ($urandom_range(0, 1) == 1) do_advance(1'b1, {r[31:2], 2'b00});
      else do_advance(1'b0, r);
    end

    // pc+4 wraps at the top of the address space.
    do_fetch(0, 32'h0000_0013);
    do_advance(1'b1, 32'hFFFF_FFFC);
    do_fetch(2, 32'h0000_0013);
    do_advance(1'b0, 32'h0);
    chk("wrap.addr", imem_addr, 32'h0);

    // Retire counter wraps.
    do_fetch(1, 32'h0000_0033);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    #1;
    chk("cnt.preload", retired, 32'hFFFF_FFFF);
    do_advance(1'b0, 32'h0);
    chk("cnt.wrap", retired, 32'd0);

    // Reset wins over a simultaneous advance.
    do_fetch(0, 32'h0000_0013);
    advance = 1'b1; pcSrc = 1'b1; pcTarget = 32'h200;
    do_reset();
    chk("rstadv.retired", retired, 32'd0);

    // Misaligned taken target traps and locks up.
    do_fetch(0, 32'h0000_0067);
    do_advance(1'b1, 32'h0000_0042);
    chk("mis.trap", {31'd0, trap}, 32'd1);
    chk("mis.pc", pc, RPC);
    for (int i = 0; i < 5; i++) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      advance    = 1'($urandom_range(0, 1));
      pcSrc      = 1'b0;
      step();
      chk_state("err");
    end
    imem_valid = 1'b0; advance = 1'b0;
    do_reset();
    chk("err.cleared", {31'd0, trap}, 32'd0);

    // Reset in the middle of a wait abandons the request.
    imem_valid = 1'b0;
    step();
    chk("midwait.req", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midwait.req_drop", {31'd0, imem_req}, 32'd0);
    imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midwait.pc", pc, RPC);
    chk("midwait.valid", {31'd0, instrValid}, 32'd0);
    chk("midwait.instr", instr, 32'h0000_0013);
    m_pc = RPC; m_instr = 32'h0000_0013; m_retired = 0;
    m_valid = 0; m_trap = 0; m_dead = 0;
    do_fetch(1, 32'h0010_0113);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
